pcgen_bp: RTL and testbench
===========================

Name: pcgen_bp

Overview:
- Next-generation PC generation stage for the pipelined RV32I core; replaces the fixed "pc+4 or ALU result" next-PC register of the single-cycle core.
- Holds the fetch PC and applies stall and EX-stage redirect.
- Contains a parametrised direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so fetch follows predicted-taken branches and jumps without waiting for EX.
- Drives the instruction memory address; fed back by EX with resolved branch outcomes.

Parameters:
- XLEN, 32, PC and target width.
- ENTRIES, 16, number of BTB entries; must be a power of two and at least 2. IDX_W = log2(ENTRIES).
- TAG_W, 8, tag bits, taken from pc[IDX_W+2+TAG_W-1 : IDX_W+2]. Requires IDX_W+2+TAG_W <= XLEN.
- RESET_PC, 32'h0, PC value after reset; must be word aligned.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous reset, active low.
- stall  in  1  hold the PC (pipeline backpressure).
- redirect  in  1  EX detected a mispredict; load redirect_pc.
- redirect_pc  in  XLEN  correct next PC from EX.
- upd_en  in  1  EX resolved a branch or jump this cycle.
- upd_pc  in  XLEN  PC of the resolved instruction.
- upd_taken  in  1  resolved outcome.
- upd_target  in  XLEN  resolved target.
- pc  out  XLEN  current fetch PC (registered).
- pred_taken  out  1  current PC is predicted taken.
- pred_target  out  XLEN  predicted target for the current PC.
- stat_hits  out  32  BTB hit counter (optional feature).
- stat_redirects  out  32  redirect counter (optional feature).

Behaviour:
- Reset (rst=0, asynchronous):
  - pc = RESET_PC.
  - All valid bits = 0; all counters = 2'b01; tags and targets = 0.
  - Outputs: pred_taken = 0, pred_target = 0, stat counters = 0.
  - Reset asserted mid-operation discards all BTB contents immediately.
- Lookup (combinational on the registered pc):
  - idx = pc[IDX_W+1:2].
  - hit = valid[idx] AND tag[idx] equals the tag field of pc.
  - pred_taken = hit AND ctr[idx][1].
  - pred_target = target[idx] on hit, otherwise 0.
  - pc[1:0] is ignored.
- Next PC, in strict priority order:
  1. redirect: pc <= redirect_pc. This overrides stall.
  2. stall: pc holds its value.
  3. pred_taken: pc <= pred_target.
  4. Otherwise: pc <= pc + 4, wrapping modulo 2^XLEN. For example, 32'hFFFFFFFC goes to 0.
- Update (at posedge when upd_en=1):
  - Entry index and tag are computed from upd_pc.
  - Entry hit, upd_taken=1: counter increments, saturating at 2'b11; target <= upd_target.
  - Entry hit, upd_taken=0: counter decrements, saturating at 2'b00; target unchanged; valid stays 1.
  - Entry miss, upd_taken=1: allocate. valid=1, tag written, target=upd_target, counter=2'b10 (weakly taken). This overwrites any aliasing entry.
  - Entry miss, upd_taken=0: no change.
- Update and stall are independent: the BTB updates even while stalled.
- Simultaneous lookup and update to the same index: the lookup in that cycle uses the old contents; the new contents are visible from the next cycle.
- Latency: a taken update at cycle N is used for prediction at cycle N+1 and later.
- Storage: flops, not RAM, so the lookup is same-cycle.

Optional Feature:
- Macro: PCGEN_BP_STATS_EN.
- Defined:
  - stat_hits increments each cycle in which hit=1, stall=0 and redirect=0.
  - stat_redirects increments each cycle redirect=1.
  - Both counters saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- Reset and sequential fetch: rst=0 then release, no updates -> pc sequence 0, 4, 8, 12 on successive cycles; pred_taken=0 throughout.
- Stall: at pc=8, stall=1 for 2 cycles -> pc stays 8 for both cycles, then continues 12.
- Allocate and predict: upd_en=1, upd_pc=0x10, upd_taken=1, upd_target=0x40; then fetch reaches 0x10 -> pred_taken=1, pred_target=0x40, next pc=0x40.
- Counter training: from that weakly-taken entry, one not-taken update at 0x10 (counter 10->01), then fetch 0x10 -> pred_taken=0, next pc=0x14. A taken update then a second taken update -> counter 11; a single not-taken leaves pred_taken=1.
- Redirect priority: stall=1 and redirect=1 with redirect_pc=0x100 in the same cycle -> pc=0x100 next cycle. With stats enabled, stat_redirects=1.
- Aliasing and wrap: with ENTRIES=16, the entry at 0x10 is valid and pc=0x50 (same idx, different tag) -> pred_taken=0. A taken update at 0x50 evicts it, after which 0x10 misses. Separately, pc=0xFFFFFFFC with no hit -> next pc=0.

Source files
------------

// File: rtl/pcgen_bp.sv
// Fetch PC generator with a direct-mapped BTB and 2-bit saturating counters.
// Define PCGEN_BP_STATS_EN to build the hit/redirect statistics counters.
module pcgen_bp #(
   parameter int               XLEN     = 32,
   parameter int               ENTRIES  = 16,
   parameter int               TAG_W    = 8,
   parameter logic [XLEN-1:0]  RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            upd_en,
   input  logic [XLEN-1:0] upd_pc,
   input  logic            upd_taken,
   input  logic [XLEN-1:0] upd_target,
   output logic [XLEN-1:0] pc,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target,
   output logic [31:0]     stat_hits,
   output logic [31:0]     stat_redirects
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_LO = IDX_W + 2;

   logic               r_valid [ENTRIES];
   logic [TAG_W-1:0]   r_tag   [ENTRIES];
   logic [XLEN-1:0]    r_tgt   [ENTRIES];
   logic [1:0]         r_ctr   [ENTRIES];
   logic [XLEN-1:0]    r_pc;

   logic [IDX_W-1:0]   w_idx;
   logic [TAG_W-1:0]   w_tag;
   logic               w_hit;
   logic [IDX_W-1:0]   w_upd_idx;
   logic [TAG_W-1:0]   w_upd_tag;
   logic               w_upd_hit;
   logic               w_unused;

   assign w_idx     = r_pc[IDX_W+1:2];
   assign w_tag     = r_pc[TAG_LO+TAG_W-1:TAG_LO];
   assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_upd_idx = upd_pc[IDX_W+1:2];
   assign w_upd_tag = upd_pc[TAG_LO+TAG_W-1:TAG_LO];
   assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
   assign w_unused  = ^{r_pc, upd_pc};

   assign pc          = r_pc;
   assign pred_taken  = w_hit && r_ctr[w_idx][1];
   assign pred_target = w_hit ? r_tgt[w_idx] : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc <= RESET_PC;
      end else if (redirect) begin
         r_pc <= redirect_pc;
      end else if (!stall) begin
         r_pc <= pred_taken ? pred_target : r_pc + XLEN'(4);
      end
   end

   // Each entry only reacts to updates addressed to it; lookups see the old
   // contents during the update cycle because the arrays are plain flops.
   generate
      for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_valid[gi] <= 1'b0;
               r_tag[gi]   <= '0;
               r_tgt[gi]   <= '0;
               r_ctr[gi]   <= 2'b01;
            end else if (upd_en && (w_upd_idx == IDX_W'(gi))) begin
               if (w_upd_hit) begin
                  if (upd_taken) begin
                     if (r_ctr[gi] != 2'b11) r_ctr[gi] <= r_ctr[gi] + 2'd1;
                     r_tgt[gi] <= upd_target;
                  end else if (r_ctr[gi] != 2'b00) begin
                     r_ctr[gi] <= r_ctr[gi] - 2'd1;
                  end
               end else if (upd_taken) begin
                  r_valid[gi] <= 1'b1;
                  r_tag[gi]   <= w_upd_tag;
                  r_tgt[gi]   <= upd_target;
                  r_ctr[gi]   <= 2'b10;
               end
            end
         end
      end
   endgenerate

`ifdef PCGEN_BP_STATS_EN
   logic [31:0] r_stat_hits;
   logic [31:0] r_stat_redirects;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stat_hits      <= '0;
         r_stat_redirects <= '0;
      end else begin
         if (w_hit && !stall && !redirect && (r_stat_hits != 32'hFFFF_FFFF))
            r_stat_hits <= r_stat_hits + 32'd1;
         if (redirect && (r_stat_redirects != 32'hFFFF_FFFF))
            r_stat_redirects <= r_stat_redirects + 32'd1;
      end
   end

   assign stat_hits      = r_stat_hits;
   assign stat_redirects = r_stat_redirects;
`else
   assign stat_hits      = '0;
   assign stat_redirects = '0;
`endif

endmodule

// File: tb/tb_pcgen_bp.sv
// Directed self-checking bench for pcgen_bp (default 16-entry, 8-bit tag build).
module tb_pcgen_bp;

`ifdef PCGEN_BP_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, redirect, upd_en, upd_taken;
   logic [31:0] redirect_pc, upd_pc, upd_target;
   logic [31:0] pc, pred_target, stat_hits, stat_redirects;
   logic        pred_taken;

   int n_tests = 0;
   int n_fail  = 0;

   pcgen_bp dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .upd_en         (upd_en),
      .upd_pc         (upd_pc),
      .upd_taken      (upd_taken),
      .upd_target     (upd_target),
      .pc             (pc),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .stat_hits      (stat_hits),
      .stat_redirects (stat_redirects)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s = %h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_redirect(input logic [31:0] target);
      redirect = 1'b1; redirect_pc = target;
      tick();
      redirect = 1'b0;
   endtask

   task automatic do_update(input logic [31:0] upc, input logic taken, input logic [31:0] tgt);
      upd_en = 1'b1; upd_pc = upc; upd_taken = taken; upd_target = tgt;
      tick();
      upd_en = 1'b0;
   endtask

   initial begin
      rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
      #12;
      check("rst_pc", pc, 32'h0);
      check("rst_pred_taken", {31'b0, pred_taken}, 32'h0);
      check("rst_pred_target", pred_target, 32'h0);
      check("rst_stat_hits", stat_hits, 32'h0);
      check("rst_stat_redirects", stat_redirects, 32'h0);
      rst = 1'b1;

      // Sequential fetch
      tick(); check("seq_pc4", pc, 32'h4);
      tick(); check("seq_pc8", pc, 32'h8);
      check("seq_no_pred", {31'b0, pred_taken}, 32'h0);

      // Stall holds for two cycles
      stall = 1'b1;
      tick(); check("stall_c1", pc, 32'h8);
      tick(); check("stall_c2", pc, 32'h8);
      stall = 1'b0;
      tick(); check("stall_release", pc, 32'hC);

      // Allocate 0x10 -> 0x40 and follow the prediction
      do_update(32'h10, 1'b1, 32'h40);
      check("alloc_pc", pc, 32'h10);
      check("alloc_pred_taken", {31'b0, pred_taken}, 32'h1);
      check("alloc_pred_target", pred_target, 32'h40);
      tick(); check("alloc_follow", pc, 32'h40);
      check("alloc_stat_hits", stat_hits, STATS ? 32'd1 : 32'd0);

      // Weaken to 01: hit but not predicted taken
      do_update(32'h10, 1'b0, 32'h0);
      check("weak_seq", pc, 32'h44);
      do_redirect(32'h10);
      check("weak_pred_taken", {31'b0, pred_taken}, 32'h0);
      check("weak_pred_target", pred_target, 32'h40);
      tick(); check("weak_next", pc, 32'h14);

      // Train to 11, one not-taken leaves it taken (BTB updates under stall)
      stall = 1'b1;
      do_update(32'h10, 1'b1, 32'h40);
      do_update(32'h10, 1'b1, 32'h40);
      do_update(32'h10, 1'b0, 32'h0);
      check("train_stalled_pc", pc, 32'h14);
      stall = 1'b0;
      do_redirect(32'h10);
      check("train_pred_taken", {31'b0, pred_taken}, 32'h1);
      tick(); check("train_follow", pc, 32'h40);

      // Redirect wins over stall
      stall = 1'b1;
      do_redirect(32'h100);
      stall = 1'b0;
      check("redir_prio_pc", pc, 32'h100);
      check("redir_prio_stat", stat_redirects, STATS ? 32'd3 : 32'd0);

      // Aliasing: 0x50 shares idx 4 with 0x10 but has a different tag
      do_redirect(32'h50);
      check("alias_miss", {31'b0, pred_taken}, 32'h0);
      check("alias_miss_target", pred_target, 32'h0);
      stall = 1'b1;
      do_update(32'h50, 1'b1, 32'h80);
      stall = 1'b0;
      check("alias_hold", pc, 32'h50);
      check("alias_evict_target", pred_target, 32'h80);
      tick(); check("alias_follow", pc, 32'h80);
      do_redirect(32'h10);
      check("alias_old_miss", {31'b0, pred_taken}, 32'h0);
      tick(); check("alias_old_seq", pc, 32'h14);

      // Same-cycle lookup/update uses old contents
      do_update(32'h14, 1'b1, 32'h200);
      check("same_cycle_old", pc, 32'h18);

      // Wrap at the top of the address space
      do_redirect(32'hFFFF_FFFC);
      check("wrap_no_pred", {31'b0, pred_taken}, 32'h0);
      tick(); check("wrap_pc", pc, 32'h0);
      check("final_stat_hits", stat_hits, STATS ? 32'd4 : 32'd0);
      check("final_stat_redirects", stat_redirects, STATS ? 32'd6 : 32'd0);

      // Asynchronous reset mid-run clears the BTB
      #3 rst = 1'b0;
      #1 check("async_rst_pc", pc, 32'h0);
      check("async_rst_stats", stat_hits, 32'h0);
      rst = 1'b1;
      tick();
      do_redirect(32'h50);
      check("post_rst_miss", {31'b0, pred_taken}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
